// File: rtl/openila_pkg.sv
// Shared definitions for the openila capture path.
package openila_pkg;

  // Capture FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_TRIG  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/openila_sample_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
// The array has no reset so it maps onto block RAM; only the read register
// is cleared by rst_n.
module openila_sample_ram #(
  parameter int W_DATA = 8,
  parameter int W_ADDR = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [W_ADDR-1:0] wr_addr,
  input  logic [W_DATA-1:0] wr_data,
  input  logic [W_ADDR-1:0] rd_addr,
  output logic [W_DATA-1:0] rd_data
);

  logic [W_DATA-1:0] mem [0:(1<<W_ADDR)-1];

  // write port
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // registered read port; same-address read during a write returns old data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/openila_capture.sv
// Capture controller: writes samples into a circular buffer once armed and
// stops a programmable number of samples after the trigger.
//
//  state | meaning
//  IDLE  | no capture; trigger ignored, waiting for arm
//  ARMED | writing every cycle, waiting for trigger
//  TRIG  | trigger seen, writing remaining post-trigger samples
//  DONE  | capture frozen for readout until arm or abort
module openila_capture
  import openila_pkg::*;
#(
  parameter int W_DATA = 8,
  parameter int W_ADDR = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W_DATA-1:0] sample,
  input  logic              trigger,
  input  logic              arm,
  input  logic              abort,
  input  logic [W_ADDR-1:0] post_count,
  output logic              armed,
  output logic              triggered,
  output logic              done,
  output logic              wrapped,
  output logic [W_ADDR-1:0] trig_addr,
  output logic [W_ADDR-1:0] wr_addr,
  input  logic [W_ADDR-1:0] rd_addr,
  output logic [W_DATA-1:0] rd_data
);

  logic [1:0]        state_q;
  logic [W_ADDR-1:0] wr_addr_q;
  logic [W_ADDR-1:0] trig_addr_q;
  logic [W_ADDR-1:0] pc_q;
  logic [W_ADDR-1:0] remain_q;
  logic              wrapped_q;
  logic              capture;

  // abort and arm pre-empt the write, so the arm cycle never stores a sample
  assign capture = !abort && !arm && (state_q == ST_ARMED || state_q == ST_TRIG);

  // FSM, write pointer, trigger address and post-trigger down-counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wr_addr_q   <= '0;
      trig_addr_q <= '0;
      pc_q        <= '0;
      remain_q    <= '0;
      wrapped_q   <= 1'b0;
    end else if (abort) begin
      state_q <= ST_IDLE;
    end else if (arm) begin
      state_q   <= ST_ARMED;
      wr_addr_q <= '0;
      wrapped_q <= 1'b0;
      pc_q      <= post_count;
    end else if (capture) begin
      wr_addr_q <= wr_addr_q + W_ADDR'(1);
      if (&wr_addr_q) wrapped_q <= 1'b1;
      if (state_q == ST_ARMED) begin
        if (trigger) begin
          trig_addr_q <= wr_addr_q;
          if (pc_q == '0) begin
            state_q <= ST_DONE;
          end else begin
            remain_q <= pc_q;
            state_q  <= ST_TRIG;
          end
        end
      end else begin
        // remain == 1 marks the last post-trigger write
        remain_q <= remain_q - W_ADDR'(1);
        if (remain_q == W_ADDR'(1)) state_q <= ST_DONE;
      end
    end
  end

  assign armed     = (state_q == ST_ARMED);
  assign triggered = (state_q == ST_TRIG);
  assign done      = (state_q == ST_DONE);
  assign wrapped   = wrapped_q;
  assign trig_addr = trig_addr_q;
  assign wr_addr   = wr_addr_q;

  openila_sample_ram #(
    .W_DATA (W_DATA),
    .W_ADDR (W_ADDR)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (capture),
    .wr_addr (wr_addr_q),
    .wr_data (sample),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_openila_capture.sv
// Bench for openila_capture: directed capture scenarios plus random traffic,
// all checked against a count-based behavioural model of the capture.
module tb_openila_capture;

  localparam int WD    = 8;
  localparam int WA    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [WD-1:0] sample = '0;
  logic          trigger = 1'b0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic [WA-1:0] post_count = '0;
  logic [WA-1:0] rd_addr = '0;
  logic          armed, triggered, done, wrapped;
  logic [WA-1:0] trig_addr, wr_addr;
  logic [WD-1:0] rd_data;

  openila_capture #(.W_DATA(WD), .W_ADDR(WA)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample     (sample),
    .trigger    (trigger),
    .arm        (arm),
    .abort      (abort),
    .post_count (post_count),
    .armed      (armed),
    .triggered  (triggered),
    .done       (done),
    .wrapped    (wrapped),
    .trig_addr  (trig_addr),
    .wr_addr    (wr_addr),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a capture is described by how many samples have been
  // written since arm, whether the trigger has been seen and how many
  // post-trigger samples are still owed.
  logic [WD-1:0] m_mem [DEPTH];
  bit            m_val [DEPTH];
  bit            m_active, m_trig_seen, m_rd_ok;
  int            m_left, m_nw, m_pc, m_taddr, m_rd;

  always @(posedge clk) begin
    bit cap;
    int wa;
    if (!rst_n) begin
      m_active = 0; m_trig_seen = 0; m_left = 0; m_nw = 0; m_pc = 0;
      m_taddr = 0; m_rd = 0; m_rd_ok = 1;
    end else begin
      cap = m_active && !abort && !arm && !(m_trig_seen && m_left == 0);
      wa  = m_nw % DEPTH;
      m_rd    = int'(m_mem[rd_addr]);
      m_rd_ok = m_val[rd_addr] && !(cap && wa == int'(rd_addr));
      if (abort) begin
        m_active = 0;
      end else if (arm) begin
        m_active = 1; m_trig_seen = 0; m_left = 0; m_nw = 0; m_pc = int'(post_count);
      end else if (cap) begin
        m_mem[wa] = sample;
        m_val[wa] = 1;
        if (!m_trig_seen) begin
          if (trigger) begin
            m_trig_seen = 1; m_taddr = wa; m_left = m_pc;
          end
        end else begin
          m_left--;
        end
        m_nw++;
      end
    end
  end

  // per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("armed",     int'(armed),     int'(m_active && !m_trig_seen));
      chk("triggered", int'(triggered), int'(m_active && m_trig_seen && m_left > 0));
      chk("done",      int'(done),      int'(m_active && m_trig_seen && m_left == 0));
      chk("wrapped",   int'(wrapped),   int'(m_nw >= DEPTH));
      chk("wr_addr",   int'(wr_addr),   m_nw % DEPTH);
      chk("trig_addr", int'(trig_addr), m_taddr);
      if (m_rd_ok) chk("rd_data", int'(rd_data), m_rd);
    end
  end

  int scnt = 0;
  bit rand_sample = 0;

  // one clock cycle of stimulus; returns just after the active edge
  task automatic tick(input bit a, input bit t, input bit ab);
    @(negedge clk);
    arm = a; trigger = t; abort = ab;
    sample = rand_sample ? WD'($urandom) : WD'(scnt);
    @(posedge clk);
    scnt = a ? 0 : scnt + 1;
    #1;
  endtask

  task automatic rd(input int a, input int exp);
    rd_addr = WA'(a);
    tick(0, 0, 0);
    chk($sformatf("rd[%0d]", a), int'(rd_data), exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset with trigger held high, no arm
    rst_n = 0; trigger = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset done",    int'(done),    0);
    chk("reset armed",   int'(armed),   0);
    chk("reset rd_data", int'(rd_data), 0);
    chk("reset wr_addr", int'(wr_addr), 0);
    @(negedge clk); rst_n = 1;
    repeat (3) tick(0, 1, 0);
    chk("idle armed",   int'(armed),   0);
    chk("idle wr_addr", int'(wr_addr), 0);
    post_count = 4'd3;
    tick(1, 1, 0);
    chk("arm cyc armed",     int'(armed),     1);
    chk("arm cyc triggered", int'(triggered), 0);
    chk("arm cyc wr_addr",   int'(wr_addr),   0);

    // 2: post_count=3, trigger on sample 4
    repeat (4) tick(0, 0, 0);
    tick(0, 1, 0);
    chk("t2 triggered", int'(triggered), 1);
    chk("t2 trig_addr", int'(trig_addr), 4);
    repeat (2) tick(0, 0, 0);
    chk("t2 done early", int'(done), 0);
    tick(0, 0, 0);
    chk("t2 done",    int'(done),    1);
    chk("t2 wr_addr", int'(wr_addr), 8);
    chk("t2 wrapped", int'(wrapped), 0);
    for (int i = 0; i < 8; i++) rd(i, i);

    // 3: post_count=5, trigger on sample 20 (buffer wraps)
    post_count = 4'd5;
    tick(1, 0, 0);
    repeat (20) tick(0, 0, 0);
    tick(0, 1, 0);
    repeat (5) tick(0, 0, 0);
    chk("t3 done",      int'(done),      1);
    chk("t3 wrapped",   int'(wrapped),   1);
    chk("t3 trig_addr", int'(trig_addr), 4);
    chk("t3 wr_addr",   int'(wr_addr),   10);
    for (int k = 0; k < 16; k++) rd((10 + k) % 16, 10 + k);

    // 6 + 4: re-arm from DONE, then post_count=0 with trigger on sample 2
    post_count = 4'd0;
    tick(1, 0, 0);
    chk("t6 done",    int'(done),    0);
    chk("t6 wrapped", int'(wrapped), 0);
    chk("t6 wr_addr", int'(wr_addr), 0);
    repeat (2) tick(0, 0, 0);
    tick(0, 1, 0);
    chk("t4 done",      int'(done),      1);
    chk("t4 wr_addr",   int'(wr_addr),   3);
    chk("t4 trig_addr", int'(trig_addr), 2);
    tick(0, 0, 0);
    chk("t4 wr_addr hold", int'(wr_addr), 3);
    for (int i = 0; i < 3; i++) rd(i, i);
    rd(3, 19);

    // 5: abort during TRIG, then arm+abort together
    post_count = 4'd5;
    tick(1, 0, 0);
    tick(0, 0, 0);
    tick(0, 1, 0);
    tick(0, 0, 0);
    chk("t5 triggered", int'(triggered), 1);
    tick(0, 0, 1);
    chk("t5 abort triggered", int'(triggered), 0);
    chk("t5 abort armed",     int'(armed),     0);
    for (int i = 0; i < 8; i++) begin
      tick(0, i[0], 0);
      chk("t5 no done", int'(done), 0);
    end
    tick(1, 0, 0);
    chk("t5 rearm", int'(armed), 1);
    tick(1, 0, 1);
    chk("t5 arm+abort armed", int'(armed), 0);
    chk("t5 arm+abort done",  int'(done),  0);

    // random traffic against the model
    rand_sample = 1;
    for (int c = 0; c < 4000; c++) begin
      post_count = WA'($urandom);
      rd_addr    = WA'($urandom);
      tick($urandom_range(0, 49) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 99) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
